// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Two-stage execution unit for the 3-bit ALU control code coming out of decode.
//   S1 registers the operation and its operands. S2 registers the result and the flags.
//   Both the input side and the output side use a valid/ready handshake.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operation presented by the producer
//   in_ready     unit can accept an operation this cycle (combinational from out_ready)
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt; every other code is illegal
//   src_a        operand A
//   src_b        operand B
//   out_valid    result presented (the S2 valid bit)
//   out_ready    consumer takes the result this cycle
//   result       computed value (registered)
//   zero         result == 0 (registered)
//   illegal      alu_control was not a supported code (registered)
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic             s1_valid;
    logic [2:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;

    logic             s1_en;
    logic             s2_en;

    logic [WIDTH-1:0] calc_result;
    logic             calc_illegal;

    // An empty S2 always advances, so a bubble in S2 never holds S1 back.
    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    assign out_valid = s2_valid;

    always_comb begin
        calc_result  = '0;
        calc_illegal = 1'b0;
        unique case (s1_ctrl)
            OP_ADD:  calc_result = s1_a + s1_b;
            OP_SUB:  calc_result = s1_a - s1_b;
            OP_AND:  calc_result = s1_a & s1_b;
            OP_OR:   calc_result = s1_a | s1_b;
            OP_SLT:  calc_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: calc_illegal = 1'b1;
        endcase
    end

    // S1: the valid bit follows in_valid whenever the stage may load.
    // The operands load only when there is a real operation to take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl <= alu_control;
                s1_a    <= src_a;
                s1_b    <= src_b;
            end
        end
    end

    // S2: the output registers. While the consumer stalls they hold their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result  <= calc_result;
                zero    <= (calc_result == '0);
                illegal <= calc_illegal;
            end
        end
    end

endmodule
